// File: rtl/adc_cfg_pkg.sv
// Shared definitions for the 3-wire SCLK/SLOAD/SDATA ADC configuration bus.
// Used by both the ADC-side responder and the FPGA-side master.
package adc_cfg_pkg;

    localparam int unsigned ADC_CFG_ADDR_W = 3;
    localparam int unsigned ADC_CFG_DATA_W = 9;
    localparam int unsigned ADC_CFG_NREGS  = 8;
    localparam int unsigned ADC_CFG_DUMP_W = ADC_CFG_NREGS * ADC_CFG_DATA_W;

    localparam int unsigned HDR_BITS   = 4;
    localparam int unsigned TURN_BITS  = 3;
    localparam int unsigned FRAME_BITS = 16;

    localparam int unsigned BIT_CNT_W   = 5;
    localparam int unsigned BIT_CNT_MAX = FRAME_BITS + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        TURN   = 2'd2,
        DATA   = 2'd3
    } adc_cfg_state_e;

    typedef struct packed {
        logic [ADC_CFG_ADDR_W-1:0] addr;
        logic [ADC_CFG_DATA_W-1:0] data;
    } adc_cfg_wr_t;

    // Rising-edge counter that sticks at one past a full frame so overlong frames abort.
    function automatic logic [BIT_CNT_W-1:0] bit_cnt_inc(input logic [BIT_CNT_W-1:0] cnt);
        return (cnt >= BIT_CNT_W'(BIT_CNT_MAX)) ? cnt : cnt + BIT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/adc_cfg_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus pin with rise/fall detection
// taken from the last two synchronized samples.
module adc_cfg_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_c =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_c = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/adc_config_responder.sv
// ADC-side responder of the 3-wire config bus: decodes oversampled frames,
// holds an 8 x 9-bit register file and drives read data back on SDATA.
module adc_config_responder
    import adc_cfg_pkg::*;
#(
    parameter int unsigned                SYNC_STAGES = 2,
    parameter logic [ADC_CFG_DUMP_W-1:0]  REG_INIT    = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      SCLK,
    input  logic                      SLOAD,
    inout  wire                       SDATA,
    output logic [ADC_CFG_DUMP_W-1:0] reg_dump,
    output logic                      wr_valid,
    output logic [ADC_CFG_ADDR_W-1:0] wr_addr,
    output logic [ADC_CFG_DATA_W-1:0] wr_data,
    output logic                      rd_valid,
    output logic [ADC_CFG_ADDR_W-1:0] rd_addr,
    output logic                      frame_err,
    output logic                      busy
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic sload_lvl, sload_rise, sload_fall;
    logic sdata_lvl, sdata_rise, sdata_fall;

    adc_cfg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .din(SCLK),
        .level(sclk_lvl), .rise_c(sclk_rise), .fall_c(sclk_fall)
    );

    adc_cfg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sload (
        .clk(clk), .reset_n(reset_n), .din(SLOAD),
        .level(sload_lvl), .rise_c(sload_rise), .fall_c(sload_fall)
    );

    adc_cfg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sdata (
        .clk(clk), .reset_n(reset_n), .din(SDATA),
        .level(sdata_lvl), .rise_c(sdata_rise), .fall_c(sdata_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, sload_lvl, sdata_rise, sdata_fall};

    adc_cfg_state_e                            state_q, state_d;
    logic [BIT_CNT_W-1:0]                      bit_cnt_q, bit_cnt_d, bit_cnt_n;
    logic [ADC_CFG_DATA_W-1:0]                 shreg_q, shreg_d;
    logic                                      rw_q, rw_d;
    logic [ADC_CFG_ADDR_W-1:0]                 addr_q, addr_d, hdr_addr;
    logic                                      oe_q, oe_d;
    logic [ADC_CFG_NREGS-1:0][ADC_CFG_DATA_W-1:0] regs_q;
    logic                                      commit;
    adc_cfg_wr_t                               wr_q, wr_d;
    logic                                      wr_valid_d, rd_valid_d, frame_err_d;
    logic [ADC_CFG_ADDR_W-1:0]                 rd_addr_d;

    assign bit_cnt_n = bit_cnt_inc(bit_cnt_q);
    assign hdr_addr  = {shreg_q[1:0], sdata_lvl};

    // Next-state and next-output logic; SLOAD rising ends the frame from any state.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        oe_d        = oe_q;
        wr_d        = wr_q;
        rd_addr_d   = rd_addr;
        wr_valid_d  = 1'b0;
        rd_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        commit      = 1'b0;

        if (state_q != IDLE && sload_rise) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS)) begin
                if (rw_q) begin
                    rd_valid_d = 1'b1;
                    rd_addr_d  = addr_q;
                end else begin
                    wr_valid_d = 1'b1;
                    wr_d.addr  = addr_q;
                    wr_d.data  = shreg_q;
                    commit     = 1'b1;
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sload_fall) begin
                        state_d   = HEADER;
                        bit_cnt_d = '0;
                        shreg_d   = '0;
                        rw_d      = 1'b0;
                        addr_d    = '0;
                        oe_d      = 1'b0;
                    end
                end
                HEADER: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_n;
                        shreg_d   = {shreg_q[ADC_CFG_DATA_W-2:0], sdata_lvl};
                        if (bit_cnt_n == BIT_CNT_W'(HDR_BITS)) begin
                            rw_d    = shreg_q[2];
                            addr_d  = hdr_addr;
                            state_d = TURN;
                            if (shreg_q[2]) begin
                                shreg_d = regs_q[hdr_addr];
                            end
                        end
                    end
                end
                TURN: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_n;
                        if (bit_cnt_n == BIT_CNT_W'(HDR_BITS + TURN_BITS)) begin
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_n;
                        if (!rw_q) begin
                            shreg_d = {shreg_q[ADC_CFG_DATA_W-2:0], sdata_lvl};
                        end
                    end
                    // First falling edge in DATA presents D8; later ones advance until D0 is out.
                    if (sclk_fall && rw_q) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else if (bit_cnt_q < BIT_CNT_W'(FRAME_BITS)) begin
                            shreg_d = {shreg_q[ADC_CFG_DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            oe_q      <= 1'b0;
            wr_q      <= '0;
            wr_valid  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_addr   <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            oe_q      <= oe_d;
            wr_q      <= wr_d;
            wr_valid  <= wr_valid_d;
            rd_valid  <= rd_valid_d;
            rd_addr   <= rd_addr_d;
            frame_err <= frame_err_d;
            busy      <= (state_d != IDLE);
        end
    end

    // Register file; reset restores the configured power-on image.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= REG_INIT;
        end else if (commit) begin
            regs_q[addr_q] <= shreg_q;
        end
    end

    assign reg_dump = regs_q;
    assign wr_addr  = wr_q.addr;
    assign wr_data  = wr_q.data;

    // Raw SLOAD in the enable lets the bus be released without waiting on the synchronizer.
    assign SDATA = (oe_q && !SLOAD) ? shreg_q[ADC_CFG_DATA_W-1] : 1'bz;

endmodule
